quad_decoder: RTL and testbench

Quadrature (A/B) decoder that converts two-phase rotary-encoder or jog-wheel inputs into up/down count steps and a wrapping position counter. It is the input-side counterpart of the board's up/down counter: it produces the direction (0 = up, 1 = down) and step events that the counter path consumes, and it also keeps its own position register. It sits directly behind the raw encoder pins in the top level, in the `clk` domain.

---
 rtl/quad_pkg.sv | 27 ++
 rtl/quad_decoder_debounce_sync.sv | 43 ++++
 rtl/quad_decoder.sv | 117 +++++++++++
 tb/tb_quad_decoder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared phase, direction and FSM definitions
// for the quadrature decoder.
package quad_pkg;

   localparam logic [1:0] PH_00 = 2'b00;
   localparam logic [1:0] PH_01 = 2'b01;
   localparam logic [1:0] PH_11 = 2'b11;
   localparam logic [1:0] PH_10 = 2'b10;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   typedef enum logic {INIT, TRACK} state_t;

   // Forward (up) neighbour in the Gray cycle
   function automatic logic [1:0] ph_fwd(
      input logic [1:0] p
   );
      case (p)
         PH_00:   ph_fwd = PH_01;
         PH_01:   ph_fwd = PH_11;
         PH_11:   ph_fwd = PH_10;
         default: ph_fwd = PH_00;
      endcase
   endfunction

endpackage

// File: rtl/quad_decoder_debounce_sync.sv
// One encoder channel: 2-flop synchronizer
// followed by a stability filter.
module debounce_sync
   import quad_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic filt
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST =
      CW'(DEBOUNCE_CYCLES - 2);

   logic          s1;
   logic          s2;
   logic [CW-1:0] cnt;

   // s1 != s2 means s2 toggles on this edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         filt <= 1'b0;
         cnt  <= '0;
      end else begin
         s1 <= din;
         s2 <= s1;
         if (s2 == filt || s1 != s2) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            filt <= s2;
            cnt  <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/quad_decoder.sv
// x4 quadrature decoder: debounced A/B phase
// tracking with step/dir/err and position count.
module quad_decoder
   import quad_pkg::*;
#(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a,
   input  logic             b,
   input  logic             clr,
   output logic [WIDTH-1:0] Q,
   output logic             step,
   output logic             dir,
   output logic             err
);

   localparam int IW = $clog2(DEBOUNCE_CYCLES + 2);
   localparam logic [IW-1:0] INIT_LAST =
      IW'(DEBOUNCE_CYCLES + 1);

   logic             fa;
   logic             fb;
   logic [1:0]       ph;
   state_t           state;
   state_t           state_nx;
   logic [IW-1:0]    icnt;
   logic [IW-1:0]    icnt_nx;
   logic [1:0]       prev;
   logic [1:0]       prev_nx;
   logic [WIDTH-1:0] q_nx;
   logic             step_nx;
   logic             dir_nx;
   logic             err_nx;

   debounce_sync #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_a (
      .clk  (clk),
      .rst  (rst),
      .din  (a),
      .filt (fa)
   );

   debounce_sync #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_b (
      .clk  (clk),
      .rst  (rst),
      .din  (b),
      .filt (fb)
   );

   assign ph = {fa, fb};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= INIT;
         icnt  <= '0;
         prev  <= PH_00;
         Q     <= '0;
         step  <= 1'b0;
         dir   <= DIR_UP;
         err   <= 1'b0;
      end else begin
         state <= state_nx;
         icnt  <= icnt_nx;
         prev  <= prev_nx;
         Q     <= q_nx;
         step  <= step_nx;
         dir   <= dir_nx;
         err   <= err_nx;
      end
   end

   always_comb begin
      state_nx = state;
      icnt_nx  = icnt;
      prev_nx  = prev;
      q_nx     = Q;
      dir_nx   = dir;
      step_nx  = 1'b0;
      err_nx   = 1'b0;
      unique case (state)
         // Wait out sync + one debounce window
         INIT: begin
            if (icnt == INIT_LAST) begin
               prev_nx  = ph;
               state_nx = TRACK;
            end else begin
               icnt_nx = icnt + 1'b1;
            end
         end
         TRACK: begin
            prev_nx = ph;
            unique case (1'b1)
               (ph == prev): ;
               (ph == ph_fwd(prev)): begin
                  q_nx    = Q + 1'b1;
                  dir_nx  = DIR_UP;
                  step_nx = 1'b1;
               end
               (prev == ph_fwd(ph)): begin
                  q_nx    = Q - 1'b1;
                  dir_nx  = DIR_DOWN;
                  step_nx = 1'b1;
               end
               default: err_nx = 1'b1;
            endcase
         end
      endcase
      if (clr) q_nx = '0;
   end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder with an
// event scoreboard popped on step/err pulses.
module tb_quad_decoder;

   localparam int W = 4;
   localparam int D = 4;

   typedef struct packed {
      logic         e;
      logic         d;
      logic [W-1:0] q;
   } ev_t;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         a   = 1'b0;
   logic         b   = 1'b0;
   logic         clr = 1'b0;
   logic [W-1:0] Q;
   logic         step;
   logic         dir;
   logic         err;

   ev_t          sb[$];
   ev_t          ev;
   int           total = 0;
   int           bad   = 0;
   logic [W-1:0] mq    = '0;
   logic         md    = 1'b0;
   int           iv[8] = '{1, 3, 2, 1, 3, 2, 2, 1};

   quad_decoder #(
      .WIDTH          (W),
      .DEBOUNCE_CYCLES(D)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .a    (a),
      .b    (b),
      .clr  (clr),
      .Q    (Q),
      .step (step),
      .dir  (dir),
      .err  (err)
   );

   always #5 clk = ~clk;

   task automatic chk(
      input string       tag,
      input logic [31:0] obs,
      input logic [31:0] exp
   );
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   task automatic pins(
      input logic na,
      input logic nb,
      input int   hold
   );
      a = na;
      b = nb;
      repeat (hold) @(negedge clk);
   endtask

   task automatic mv(
      input logic na,
      input logic nb,
      input logic up
   );
      mq = up ? mq + 1'b1 : mq - 1'b1;
      md = ~up;
      sb.push_back(ev_t'{e: 1'b0, d: md, q: mq});
      pins(na, nb, 10);
   endtask

   always @(negedge clk) begin
      if (rst && (step || err)) begin
         chk("step_err_excl", step & err, 0);
         chk("event_expected", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            ev = sb.pop_front();
            chk("ev_err", err, ev.e);
            chk("ev_dir", dir, ev.d);
            chk("ev_q", Q, ev.q);
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_q", Q, 0);
      chk("rst_step", step, 0);
      chk("rst_dir", dir, 0);
      chk("rst_err", err, 0);
      rst = 1'b1;
      repeat (12) @(negedge clk);
      chk("init_q", Q, 0);

      // forward rotation with latency check
      mq = 1;
      md = 1'b0;
      sb.push_back(ev_t'{e: 1'b0, d: 1'b0, q: mq});
      a = 1'b0;
      b = 1'b1;
      repeat (5) @(posedge clk);
      #1 chk("lat_early", step, 0);
      @(posedge clk);
      #1 chk("lat_step", step, 1);
      repeat (10) @(negedge clk);
      mv(1, 1, 1);
      mv(1, 0, 1);
      mv(0, 0, 1);
      chk("fwd_q", Q, 4);
      chk("fwd_dir", dir, 0);
      chk("fwd_sb", sb.size(), 0);

      // reverse and wrap
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      mq  = 0;
      chk("clr_q", Q, 0);
      mv(1, 0, 0);
      chk("rev_wrap_q", Q, 15);
      chk("rev_dir", dir, 1);
      mv(1, 1, 0);
      chk("rev_q", Q, 14);
      for (int i = 0; i < 4; i++) begin
         mv(1, 0, 1);
         mv(0, 0, 1);
         mv(0, 1, 1);
         mv(1, 1, 1);
      end
      chk("fwd16_q", Q, 14);
      chk("fwd16_dir", dir, 0);
      chk("fwd16_sb", sb.size(), 0);

      // bounce rejection from phase 01, Q=0
      mv(1, 0, 1);
      mv(0, 0, 1);
      mv(0, 1, 1);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      mq  = 0;
      for (int i = 0; i < 8; i++) begin
         a = ~a;
         repeat (iv[i]) @(negedge clk);
      end
      mv(1, 1, 1);
      chk("bounce_q", Q, 1);
      chk("bounce_sb", sb.size(), 0);
      b = 1'b0;
      repeat (3) @(negedge clk);
      pins(1, 1, 10);
      chk("glitch_q", Q, 1);

      // illegal transition 00 -> 11
      mv(1, 0, 1);
      mv(0, 0, 1);
      sb.push_back(ev_t'{e: 1'b1, d: md, q: mq});
      pins(1, 1, 10);
      chk("ill_q", Q, 3);
      chk("ill_sb", sb.size(), 0);
      mv(1, 0, 1);
      chk("ill_next_q", Q, 4);

      // clr colliding with an up step
      mq = 0;
      md = 1'b0;
      sb.push_back(ev_t'{e: 1'b0, d: 1'b0, q: mq});
      a = 1'b0;
      b = 1'b0;
      repeat (5) @(negedge clk);
      clr = 1'b1;
      @(posedge clk);
      #1;
      chk("coll_step", step, 1);
      chk("coll_dir", dir, 0);
      chk("coll_q", Q, 0);
      @(negedge clk);
      clr = 1'b0;
      repeat (8) @(negedge clk);
      chk("coll_sb", sb.size(), 0);

      // reset release with pins at 11
      rst = 1'b0;
      a   = 1'b1;
      b   = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      mq  = 0;
      md  = 1'b0;
      repeat (15) @(negedge clk);
      chk("init11_q", Q, 0);
      chk("init11_sb", sb.size(), 0);

      // async reset mid-rotation at Q=7
      mv(1, 0, 1);
      mv(0, 0, 1);
      mv(0, 1, 1);
      mv(1, 1, 1);
      mv(1, 0, 1);
      mv(0, 0, 1);
      mv(0, 1, 1);
      chk("mid_q", Q, 7);
      #2 rst = 1'b0;
      #1;
      chk("async_q", Q, 0);
      chk("async_dir", dir, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d",
               total, bad);
      $finish;
   end

endmodule
